// File: rtl/alu_pipe.sv
// alu_pipe: four-operation signed ALU carried through a STAGES-deep
// valid/ready pipeline with per-result flags, sticky flags and a beat counter.
module alu_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_arg0,
  input  logic [WIDTH-1:0] i_arg1,
  input  logic [1:0]       i_oper,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flag,
  input  logic             i_sticky_clr,
  output logic [1:0]       o_sticky,
  output logic [CNT_W-1:0] o_count
);

  localparam int LW = $clog2(WIDTH + 1);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [3:0]       flag;
  } beat_t;

  logic             en;
  logic             hs;
  logic [3:0]       op_sel;
  logic [WIDTH-1:0] diff;
  logic [LW-1:0]    lead;
  logic [LW-1:0]    idx;
  logic             run;
  logic [WIDTH-1:0] res_c;
  logic             err_c;
  logic             ovf_c;
  logic             neg_c;
  logic             pos_c;
  beat_t            beat_c;

  logic [STAGES-1:0] vld_q;
  beat_t             data_q [STAGES];
  logic [1:0]        sticky_q;
  logic [CNT_W-1:0]  count_q;

  assign en     = ~o_valid | i_ready;
  assign o_ready = en;
  assign hs     = o_valid & i_ready;
  assign op_sel = 4'b0001 << i_oper;

  always_comb begin
    diff = i_arg0 - i_arg1;
    lead = '0;
    run  = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      run  = run & i_arg0[i];
      lead = lead + LW'(run);
    end
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_arg0[i]) idx = LW'(i);
    end
  end

  always_comb begin
    res_c = '0;
    err_c = 1'b0;
    ovf_c = 1'b0;
    unique case (1'b1)
      op_sel[0]: begin
        res_c = diff;
        ovf_c = (i_arg0[WIDTH-1] ^ i_arg1[WIDTH-1])
              & (diff[WIDTH-1] ^ i_arg0[WIDTH-1]);
      end
      op_sel[1]: res_c = ~(i_arg0 & i_arg1);
      op_sel[2]: res_c = WIDTH'(lead);
      op_sel[3]: begin
        // only a single set bit decodes; anything else is an error
        if ($onehot(i_arg0)) res_c = WIDTH'(idx);
        else                 err_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign neg_c  = res_c[WIDTH-1] & (|res_c);
  assign pos_c  = ~res_c[WIDTH-1] & (|res_c);
  assign beat_c = '{result: res_c,
                    flag:   {ovf_c, pos_c, neg_c, err_c}};

  // every stage moves together; bubbles are kept in place
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else if (en) begin
      vld_q[0]  <= i_valid;
      data_q[0] <= beat_c;
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign o_valid  = vld_q[STAGES-1];
  assign o_result = data_q[STAGES-1].result;
  assign o_flag   = data_q[STAGES-1].flag;

  // a beat leaving during a clear still records its own flags
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sticky_q <= '0;
    end else if (i_sticky_clr) begin
      sticky_q <= hs ? {o_flag[3], o_flag[0]} : 2'b00;
    end else if (hs) begin
      sticky_q <= sticky_q | {o_flag[3], o_flag[0]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      count_q <= '0;
    end else if (hs) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign o_sticky = sticky_q;
  assign o_count  = count_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=4, STAGES=2),
// with a second CNT_W=2 instance sharing the inputs for counter wrap.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       valid = 1'b0;
  logic       rdy = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] a0 = '0;
  logic [3:0] a1 = '0;
  logic [1:0] op = '0;

  logic       ordy, vout;
  logic [3:0] result, flag;
  logic [1:0] sticky;
  logic [7:0] count;

  logic       ordy2, vout2;
  logic [3:0] result2, flag2;
  logic [1:0] sticky2;
  logic [1:0] count2;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(4), .STAGES(2), .CNT_W(8)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .o_ready(ordy),
    .i_arg0(a0), .i_arg1(a1), .i_oper(op), .o_valid(vout),
    .i_ready(rdy), .o_result(result), .o_flag(flag),
    .i_sticky_clr(clr), .o_sticky(sticky), .o_count(count)
  );

  alu_pipe #(.WIDTH(4), .STAGES(2), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .o_ready(ordy2),
    .i_arg0(a0), .i_arg1(a1), .i_oper(op), .o_valid(vout2),
    .i_ready(rdy), .o_result(result2), .o_flag(flag2),
    .i_sticky_clr(clr), .o_sticky(sticky2), .o_count(count2)
  );

  // returns {flag[3:0], result[3:0]}
  function automatic logic [7:0] model(input logic [3:0] a, b,
                                       input logic [1:0] o);
    logic [3:0] r;
    logic e, v;
    int n;
    r = '0; e = 1'b0; v = 1'b0;
    case (o)
      2'd0: begin
        r = a - b;
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      2'd1: r = ~(a & b);
      2'd2: begin
        n = 0;
        while (n < 4 && a[3-n]) n++;
        r = 4'(n);
      end
      default: begin
        case (a)
          4'b0001: r = 4'd0;
          4'b0010: r = 4'd1;
          4'b0100: r = 4'd2;
          4'b1000: r = 4'd3;
          default: e = 1'b1;
        endcase
      end
    endcase
    return {v, (!r[3] && r != 0), (r[3] && r != 0), e, r};
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      if (vout && rdy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got=%b/%b", result, flag);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          if ({flag, result} !== e) begin
            errors++;
            $display("FAIL sb_beat got r=%b f=%b exp r=%b f=%b",
                     result, flag, e[3:0], e[7:4]);
          end
        end
      end
      if (valid && ordy) sb.push_back(model(a0, a1, op));
    end
  end

  task automatic do_reset();
    rstn = 1'b0; valid = 1'b0; clr = 1'b0; rdy = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [3:0] a, b, input logic [1:0] o);
    int n;
    n = 0;
    valid = 1'b1; a0 = a; a1 = b; op = o;
    @(negedge clk);
    while (!ordy && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL send_timeout got ready=%b exp 1", ordy);
    end
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rdy = 1'b1;
    while (sb.size() > 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got pending=%0d exp 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic one(input logic [3:0] a, b, input logic [1:0] o,
                     input logic [3:0] er, ef);
    int n;
    send(a, b, o);
    n = 0;
    @(negedge clk);
    while (!vout && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!vout || result !== er || flag !== ef) begin
      errors++;
      $display("FAIL one_op%0d got v=%b r=%b f=%b exp r=%b f=%b",
               o, vout, result, flag, er, ef);
    end
    @(posedge clk); #1;
  endtask

  task automatic clr_sticky();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++;
    if (sticky !== 2'b00) begin
      errors++;
      $display("FAIL sticky_clr got=%b exp 00", sticky);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (vout !== 1'b0 || ordy !== 1'b1 || result !== 4'd0 ||
        flag !== 4'd0 || sticky !== 2'd0 || count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b rdy=%b r=%b f=%b s=%b c=%0d exp 0 1 0 0 0 0",
               vout, ordy, result, flag, sticky, count);
    end
  endtask

  task automatic test_sub_overflow();
    send(4'd3, 4'b1010, 2'd0);
    @(negedge clk);
    checks++;
    if (vout !== 1'b0) begin
      errors++;
      $display("FAIL latency_early got v=%b exp 0", vout);
    end
    @(negedge clk);
    checks++;
    if (vout !== 1'b1 || result !== 4'b1001 || flag !== 4'b1010) begin
      errors++;
      $display("FAIL sub_ovf got v=%b r=%b f=%b exp 1 1001 1010",
               vout, result, flag);
    end
    @(posedge clk); #1;
    checks++;
    if (sticky !== 2'b10) begin
      errors++;
      $display("FAIL sub_sticky got=%b exp 10", sticky);
    end
  endtask

  task automatic test_nand();
    one(4'b1111, 4'b1111, 2'd1, 4'b0000, 4'b0000);
    one(4'b0101, 4'b0011, 2'd1, 4'b1110, 4'b0010);
  endtask

  task automatic test_decode();
    clr_sticky();
    one(4'b1101, 4'd0, 2'd2, 4'd2, 4'b0100);
    one(4'b1111, 4'd0, 2'd2, 4'd4, 4'b0100);
    one(4'b0100, 4'd0, 2'd3, 4'd2, 4'b0100);
    one(4'b0110, 4'd0, 2'd3, 4'd0, 4'b0001);
    checks++;
    if (sticky !== 2'b01) begin
      errors++;
      $display("FAIL decode_sticky got=%b exp 01", sticky);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] held_r;
    logic [3:0] held_f;
    do_reset();
    send(4'd1, 4'd2, 2'd0);
    send(4'd5, 4'd3, 2'd1);
    rdy = 1'b0;
    valid = 1'b1; a0 = 4'b1100; a1 = 4'd0; op = 2'd2;
    held_r = result;
    held_f = flag;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ordy !== 1'b0 || vout !== 1'b1 ||
          result !== held_r || flag !== held_f) begin
        errors++;
        $display("FAIL stall_%0d got rdy=%b v=%b r=%b exp 0 1 %b",
                 i, ordy, vout, result, held_r);
      end
    end
    @(posedge clk); #1;
    rdy = 1'b1;
    send(4'b1100, 4'd0, 2'd2);
    send(4'b1000, 4'd0, 2'd3);
    drain();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (count !== 8'd4 || count2 !== 2'd0) begin
      errors++;
      $display("FAIL bp_count got=%0d/%0d exp 4/0", count, count2);
    end
  endtask

  task automatic collide(input logic [3:0] a, b, input logic [1:0] o,
                         input logic [1:0] es);
    int n;
    send(a, b, o);
    n = 0;
    @(negedge clk);
    while (!vout && n < 20) begin
      n++;
      @(negedge clk);
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++;
    if (sticky !== es) begin
      errors++;
      $display("FAIL collide_op%0d got=%b exp %b", o, sticky, es);
    end
  endtask

  task automatic test_sticky_clear();
    send(4'd3, 4'b1010, 2'd0);
    send(4'b0110, 4'd0, 2'd3);
    drain();
    checks++;
    if (sticky !== 2'b11) begin
      errors++;
      $display("FAIL sticky_set got=%b exp 11", sticky);
    end
    collide(4'b0101, 4'b0011, 2'd1, 2'b00);
    collide(4'd3, 4'b1010, 2'd0, 2'b10);
    drain();
  endtask

  task automatic test_reset_midflight();
    send(4'd7, 4'b1001, 2'd0);
    send(4'b0010, 4'd0, 2'd3);
    #1 rstn = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (vout !== 1'b0 || result !== 4'd0 || flag !== 4'd0 ||
        sticky !== 2'd0 || count !== 8'd0) begin
      errors++;
      $display("FAIL midflight_reset got v=%b r=%b f=%b s=%b c=%0d exp all 0",
               vout, result, flag, sticky, count);
    end
    @(posedge clk);
    #2 rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (vout !== 1'b0) begin
        errors++;
        $display("FAIL stale_valid_%0d got=%b exp 0", i, vout);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_count_wrap();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(4'(i), 4'(i + 1), 2'(i));
    end
    drain();
    checks++;
    if (count2 !== 2'd1 || count !== 8'd5) begin
      errors++;
      $display("FAIL count_wrap got=%0d/%0d exp 1/5", count2, count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_sub_overflow();
    test_nand();
    test_decode();
    test_backpressure();
    test_sticky_clear();
    test_reset_midflight();
    test_count_wrap();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
